fwrisc_exec_seq: RTL and testbench
==================================

Name: fwrisc_exec_seq

Overview:
- Execute-stage sequencer for the fwrisc core.
- Accepts one decoded operation at a time from decode and routes it to either the single-cycle ALU or the multi-cycle mul/div/shift unit (MDS).
- Waits for the selected unit's result, then issues exactly one register-file writeback.
- Sits between decode and the ALU/MDS datapath and owns the decode_valid/exec_ready handshake.

Parameters:
- ENABLE_MUL_DIV, 1, when 0 any MDS op with op[5:3]!=0 (mul/div) is treated as illegal; shifts still go to MDS.
- MDS_TIMEOUT, 64, maximum cycles to wait for mds_out_valid after issue; range 2..255.

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high reset
- decode_valid  in  1  decode presents an operation
- exec_ready  out  1  sequencer can accept; transfer occurs when decode_valid && exec_ready
- op_type  in  2  0=ALU, 1=MDS, 2=NOP, 3=illegal
- op  in  6  unit operation code
- op_a  in  32  operand A
- op_b  in  32  operand B
- rd_addr  in  6  destination register
- alu_a, alu_b  out  32  latched operands to ALU
- alu_op  out  3  latched op[2:0]
- alu_out  in  32  ALU combinational result
- mds_a, mds_b  out  32  latched operands to MDS
- mds_op  out  6  latched op
- mds_in_valid  out  1  one-cycle issue strobe
- mds_out  in  32  MDS result
- mds_out_valid  in  1  MDS result strobe
- rd_waddr  out  6  writeback address
- rd_wdata  out  32  writeback data
- rd_wen  out  1  writeback strobe
- exec_exc  out  1  one-cycle exception strobe
- exc_cause  out  2  1=illegal op, 2=MDS timeout; valid with exec_exc

Behaviour:
- Reset: state=IDLE, exec_ready=1; rd_wen=0, rd_wdata=0, rd_waddr=0; mds_in_valid=0, exec_exc=0, exc_cause=0; operand/op registers=0; timeout counter=0.
- States: IDLE, ALU, MDS_ISSUE, MDS_WAIT, WB, EXC.
- exec_ready is 1 only in IDLE and is a registered state decode, not a combinational function of decode_valid.
- IDLE, on transfer: latch op_a, op_b, op, rd_addr into the alu_*/mds_* registers and the address register. Next state by op_type:
  - 0 -> ALU
  - 1 -> MDS_ISSUE; goes to EXC instead if ENABLE_MUL_DIV=0 && op[5:3]!=0
  - 2 -> IDLE, no write
  - 3 -> EXC
- ALU (1 cycle): rd_wdata <= alu_out -> WB.
- MDS_ISSUE (1 cycle): mds_in_valid=1, counter <= 0 -> MDS_WAIT.
- MDS_WAIT:
  - if mds_out_valid: rd_wdata <= mds_out -> WB.
  - else if counter==MDS_TIMEOUT-1: -> EXC with cause 2.
  - else counter++.
  - mds_out_valid and timeout in the same cycle: result wins.
- mds_out_valid outside MDS_WAIT is ignored.
- WB (1 cycle): rd_wen=1 unless latched rd_addr==0; rd_waddr=latched rd_addr -> IDLE.
- EXC (1 cycle): exec_exc=1 with exc_cause; rd_wen=0 -> IDLE.
- Latencies (transfer at cycle N):
  - ALU: rd_wen at N+2, exec_ready at N+3.
  - NOP: exec_ready at N+1.
  - MDS: rd_wen one cycle after the mds_out_valid cycle.
- Operand/op registers hold their value from transfer until the next transfer. ALU/MDS inputs are stable for the whole operation.
- Reset mid-operation (any state) returns to IDLE within one cycle. No rd_wen or exec_exc may follow it. An MDS result arriving after reset is ignored.
- op_a/op_b changing after transfer has no effect.
- decode_valid while not ready is ignored; no queueing.
- rd_wdata is retained after WB.

Test Plan:
- Reset, then decode_valid with op_type=0, op_a=5, op_b=7, ALU model add, rd_addr=3 -> rd_wen=1 at N+2 with rd_waddr=3, rd_wdata=12; exec_ready low N+1..N+2.
- MDS op, rd_addr=10, model returns out=0xDEADBEEF 5 cycles after mds_in_valid -> single mds_in_valid pulse at N+1; rd_wen one cycle after out_valid, rd_wdata=0xDEADBEEF.
- MDS op, MDS_TIMEOUT=8, out_valid never asserted -> exec_exc=1, exc_cause=2 exactly 8 cycles after the MDS_WAIT entry cycle; no rd_wen; exec_ready returns.
- op_type=3, and separately ENABLE_MUL_DIV=0 with op=6'b001000 -> exec_exc=1, exc_cause=1 at N+1; no mds_in_valid; no rd_wen.
- ALU op with rd_addr=0 -> no rd_wen. NOP -> exec_ready back at N+1. Back-to-back decode_valid held high -> transfers spaced by full op latency, none lost or duplicated.
- Reset asserted during MDS_WAIT, then mds_out_valid pulses -> no rd_wen; exec_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/fwrisc_exec_seq.sv
// Execute-stage sequencer: accepts one decoded op, routes it to the ALU or the
// mul/div/shift unit, waits for the result and issues a single writeback.
module fwrisc_exec_seq #(
   parameter int unsigned ENABLE_MUL_DIV = 1,
   parameter int unsigned MDS_TIMEOUT    = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        decode_valid,
   output logic        exec_ready,
   input  logic [1:0]  op_type,
   input  logic [5:0]  op,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic [5:0]  rd_addr,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_op,
   input  logic [31:0] alu_out,
   output logic [31:0] mds_a,
   output logic [31:0] mds_b,
   output logic [5:0]  mds_op,
   output logic        mds_in_valid,
   input  logic [31:0] mds_out,
   input  logic        mds_out_valid,
   output logic [5:0]  rd_waddr,
   output logic [31:0] rd_wdata,
   output logic        rd_wen,
   output logic        exec_exc,
   output logic [1:0]  exc_cause
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ALU,
      S_MDS_ISSUE,
      S_MDS_WAIT,
      S_WB,
      S_EXC
   } state_t;

   localparam logic [1:0] OP_ALU = 2'd0;
   localparam logic [1:0] OP_MDS = 2'd1;
   localparam logic [1:0] OP_NOP = 2'd2;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
   localparam logic [7:0] TO_LAST = 8'(MDS_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  cause_d;
   logic [31:0] a_q, b_q;
   logic [5:0]  op_q, addr_q;
   logic        ready_q;
   logic        mds_in_valid_q;
   logic        rd_wen_q;
   logic [5:0]  rd_waddr_q;
   logic        exc_q;
   logic [1:0]  cause_q;
   logic        xfer;
   logic        muldiv_illegal;

   assign xfer           = decode_valid && ready_q;
   assign muldiv_illegal = (ENABLE_MUL_DIV == 0) && (op[5:3] != 3'd0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wdata_d = wdata_q;
      cause_d = 2'd0;
      case (state_q)
         S_IDLE: begin
            if (xfer) begin
               case (op_type)
                  OP_ALU: state_d = S_ALU;
                  OP_MDS: begin
                     if (muldiv_illegal) begin
                        state_d = S_EXC;
                        cause_d = CAUSE_ILLEGAL;
                     end else begin
                        state_d = S_MDS_ISSUE;
                     end
                  end
                  OP_NOP: state_d = S_IDLE;
                  default: begin
                     state_d = S_EXC;
                     cause_d = CAUSE_ILLEGAL;
                  end
               endcase
            end
         end
         S_ALU: begin
            wdata_d = alu_out;
            state_d = S_WB;
         end
         S_MDS_ISSUE: begin
            cnt_d   = 8'd0;
            state_d = S_MDS_WAIT;
         end
         S_MDS_WAIT: begin
            // A result in the final wait cycle still beats the timeout
            if (mds_out_valid) begin
               wdata_d = mds_out;
               state_d = S_WB;
            end else if (cnt_q == TO_LAST) begin
               state_d = S_EXC;
               cause_d = CAUSE_TIMEOUT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_WB:    state_d = S_IDLE;
         S_EXC:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Strobes are registered from the next state so they line up with the state itself
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= S_IDLE;
         cnt_q          <= 8'd0;
         wdata_q        <= 32'd0;
         a_q            <= 32'd0;
         b_q            <= 32'd0;
         op_q           <= 6'd0;
         addr_q         <= 6'd0;
         ready_q        <= 1'b1;
         mds_in_valid_q <= 1'b0;
         rd_wen_q       <= 1'b0;
         rd_waddr_q     <= 6'd0;
         exc_q          <= 1'b0;
         cause_q        <= 2'd0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         wdata_q        <= wdata_d;
         ready_q        <= (state_d == S_IDLE);
         mds_in_valid_q <= (state_d == S_MDS_ISSUE);
         rd_wen_q       <= (state_d == S_WB) && (addr_q != 6'd0);
         exc_q          <= (state_d == S_EXC);
         cause_q        <= (state_d == S_EXC) ? cause_d : 2'd0;
         if (state_d == S_WB) begin
            rd_waddr_q <= addr_q;
         end
         if (xfer) begin
            a_q    <= op_a;
            b_q    <= op_b;
            op_q   <= op;
            addr_q <= rd_addr;
         end
      end
   end

   assign exec_ready   = ready_q;
   assign alu_a        = a_q;
   assign alu_b        = b_q;
   assign alu_op       = op_q[2:0];
   assign mds_a        = a_q;
   assign mds_b        = b_q;
   assign mds_op       = op_q;
   assign mds_in_valid = mds_in_valid_q;
   assign rd_waddr     = rd_waddr_q;
   assign rd_wdata     = wdata_q;
   assign rd_wen       = rd_wen_q;
   assign exec_exc     = exc_q;
   assign exc_cause    = cause_q;

endmodule

// File: tb/tb_fwrisc_exec_seq.sv
// Scoreboard bench for fwrisc_exec_seq: a second instance covers the
// mul/div-disabled configuration.
module tb_fwrisc_exec_seq;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        decode_valid = 1'b0;
   logic        decode_valid2 = 1'b0;
   logic [1:0]  op_type = 2'd0;
   logic [5:0]  op = 6'd0;
   logic [31:0] op_a = 32'd0;
   logic [31:0] op_b = 32'd0;
   logic [5:0]  rd_addr = 6'd0;

   logic        exec_ready, mds_in_valid, rd_wen, exec_exc;
   logic [31:0] alu_a, alu_b, alu_out, mds_a, mds_b, mds_out, rd_wdata;
   logic [2:0]  alu_op;
   logic [5:0]  mds_op, rd_waddr;
   logic [1:0]  exc_cause;
   logic        mds_out_valid;

   logic        exec_ready2, mds_in_valid2, rd_wen2, exec_exc2;
   logic [31:0] alu_a2, alu_b2, alu_out2, mds_a2, mds_b2, rd_wdata2;
   logic [2:0]  alu_op2;
   logic [5:0]  mds_op2, rd_waddr2;
   logic [1:0]  exc_cause2;

   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   int          mds_pulses = 0;
   int          mds_last = -1;
   int          wen_count = 0;

   int          m_delay = 5;
   bit          m_respond = 1'b1;
   logic [31:0] m_val = 32'd0;
   logic [7:0]  m_cnt = 8'd0;
   logic        model_ov = 1'b0;

   typedef struct {
      int          kind;   // 1 = writeback, 2 = exception
      logic [5:0]  addr;
      logic [31:0] data;
      logic [1:0]  cause;
      int          cyc;
   } ev_t;
   ev_t sbq[$];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   assign alu_out       = alu_a + alu_b;
   assign alu_out2      = alu_a2 + alu_b2;
   assign mds_out       = m_val;
   assign mds_out_valid = model_ov;

   // MDS model: result arrives m_delay cycles after the issue strobe
   always @(posedge clock) begin
      model_ov <= 1'b0;
      if (mds_in_valid && m_respond) begin
         m_cnt <= 8'(m_delay - 1);
      end else if (m_cnt != 8'd0) begin
         m_cnt <= m_cnt - 8'd1;
         if (m_cnt == 8'd1) model_ov <= 1'b1;
      end
   end

   fwrisc_exec_seq #(.ENABLE_MUL_DIV(1), .MDS_TIMEOUT(8)) dut (
      .clock(clock), .reset(reset), .decode_valid(decode_valid), .exec_ready(exec_ready),
      .op_type(op_type), .op(op), .op_a(op_a), .op_b(op_b), .rd_addr(rd_addr),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
      .mds_a(mds_a), .mds_b(mds_b), .mds_op(mds_op), .mds_in_valid(mds_in_valid),
      .mds_out(mds_out), .mds_out_valid(mds_out_valid),
      .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .rd_wen(rd_wen),
      .exec_exc(exec_exc), .exc_cause(exc_cause)
   );

   fwrisc_exec_seq #(.ENABLE_MUL_DIV(0), .MDS_TIMEOUT(4)) dut2 (
      .clock(clock), .reset(reset), .decode_valid(decode_valid2), .exec_ready(exec_ready2),
      .op_type(op_type), .op(op), .op_a(op_a), .op_b(op_b), .rd_addr(rd_addr),
      .alu_a(alu_a2), .alu_b(alu_b2), .alu_op(alu_op2), .alu_out(alu_out2),
      .mds_a(mds_a2), .mds_b(mds_b2), .mds_op(mds_op2), .mds_in_valid(mds_in_valid2),
      .mds_out(32'd0), .mds_out_valid(1'b0),
      .rd_waddr(rd_waddr2), .rd_wdata(rd_wdata2), .rd_wen(rd_wen2),
      .exec_exc(exec_exc2), .exc_cause(exc_cause2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Monitor: every writeback/exception must match the head of the scoreboard
   always @(negedge clock) begin
      ev_t e;
      if (mds_in_valid) begin
         mds_pulses++;
         mds_last = cyc;
      end
      if (rd_wen) begin
         wen_count++;
         if (sbq.size() == 0) begin
            chk("unexpected_wen", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            chk("wb_kind", 32'(e.kind), 32'd1);
            chk("wb_addr", 32'(rd_waddr), 32'(e.addr));
            chk("wb_data", rd_wdata, e.data);
            chk("wb_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
      if (exec_exc) begin
         if (sbq.size() == 0) begin
            chk("unexpected_exc", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            chk("exc_kind", 32'(e.kind), 32'd2);
            chk("exc_cause", 32'(exc_cause), 32'(e.cause));
            chk("exc_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   // Presents one op on the primary DUT, pushes the expected event once the
   // transfer cycle is known, and returns at the negedge after the transfer.
   task automatic issue(input logic [1:0] t, input logic [5:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] rd, input int kind,
                        input logic [31:0] data, input logic [1:0] cause, input int lat,
                        input bit hold, output int n);
      int w;
      ev_t e;
      decode_valid = 1'b1;
      op_type = t; op = o; op_a = a; op_b = b; rd_addr = rd;
      w = 0;
      while (!exec_ready && w < 50) begin
         @(negedge clock);
         w++;
      end
      if (!exec_ready) begin
         chk("issue_wait", 32'd0, 32'd1);
         decode_valid = 1'b0;
         n = -1;
      end else begin
         n = cyc;
         if (kind != 0) begin
            e.kind = kind; e.addr = rd; e.data = data; e.cause = cause; e.cyc = n + lat;
            sbq.push_back(e);
         end
         @(negedge clock);
         if (!hold) begin
            decode_valid = 1'b0;
            op_a = 32'hBAD0BAD0;
            op_b = 32'h0BADF00D;
         end
      end
   endtask

   task automatic idle_cycles(input int k);
      for (int i = 0; i < k; i++) @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, n0, n1, n2, n3, p0, w0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("rst_exec_ready", 32'(exec_ready), 32'd1);
      chk("rst_rd_wen", 32'(rd_wen), 32'd0);
      chk("rst_rd_wdata", rd_wdata, 32'd0);
      chk("rst_rd_waddr", 32'(rd_waddr), 32'd0);
      chk("rst_mds_in_valid", 32'(mds_in_valid), 32'd0);
      chk("rst_exc", {29'd0, exc_cause, exec_exc}, 32'd0);
      chk("rst_operands", alu_a | alu_b | 32'(mds_op), 32'd0);

      // ALU add with ready-low window and operand change after transfer
      issue(2'd0, 6'd0, 32'd5, 32'd7, 6'd3, 1, 32'd12, 2'd0, 2, 1'b0, n);
      chk("alu_ready_n1", 32'(exec_ready), 32'd0);
      chk("alu_a_latched", alu_a, 32'd5);
      @(negedge clock);
      chk("alu_ready_n2", 32'(exec_ready), 32'd0);
      @(negedge clock);
      chk("alu_ready_n3", 32'(exec_ready), 32'd1);
      issue(2'd0, 6'd5, 32'hFFFF_FFFF, 32'd1, 6'd63, 1, 32'd0, 2'd0, 2, 1'b0, n);
      chk("alu_op_latched", 32'(alu_op), 32'd5);
      idle_cycles(3);

      // ALU to x0: no writeback, data still captured
      w0 = wen_count;
      issue(2'd0, 6'd0, 32'd100, 32'd23, 6'd0, 0, 32'd0, 2'd0, 0, 1'b0, n);
      idle_cycles(4);
      chk("x0_no_wen", 32'(wen_count - w0), 32'd0);
      chk("x0_wdata", rd_wdata, 32'd123);

      // NOP
      issue(2'd2, 6'd0, 32'd1, 32'd1, 6'd4, 0, 32'd0, 2'd0, 0, 1'b0, n);
      chk("nop_ready_n1", 32'(exec_ready), 32'd1);

      // MDS result after 5 cycles
      m_respond = 1'b1; m_delay = 5; m_val = 32'hDEADBEEF;
      p0 = mds_pulses;
      issue(2'd1, 6'd9, 32'h1111, 32'h2222, 6'd10, 1, 32'hDEADBEEF, 2'd0, 7, 1'b0, n);
      @(negedge clock);
      chk("mds_a_stable", mds_a, 32'h1111);
      chk("mds_op_latched", 32'(mds_op), 32'd9);
      idle_cycles(8);
      chk("mds_pulse_count", 32'(mds_pulses - p0), 32'd1);
      chk("mds_pulse_cycle", 32'(mds_last), 32'(n + 1));

      // Result on the last wait cycle wins over timeout
      m_delay = 8; m_val = 32'hCAFE0008;
      issue(2'd1, 6'd1, 32'd3, 32'd4, 6'd11, 1, 32'hCAFE0008, 2'd0, 10, 1'b0, n);
      idle_cycles(12);

      // Timeout
      m_respond = 1'b0;
      issue(2'd1, 6'd2, 32'd3, 32'd4, 6'd12, 2, 32'd0, 2'd2, 10, 1'b0, n);
      idle_cycles(10);
      chk("to_ready_back", 32'(exec_ready), 32'd1);
      m_respond = 1'b1;

      // Illegal op_type
      p0 = mds_pulses;
      w0 = wen_count;
      issue(2'd3, 6'd8, 32'd1, 32'd2, 6'd13, 2, 32'd0, 2'd1, 1, 1'b0, n);
      idle_cycles(3);
      chk("ill_no_mds", 32'(mds_pulses - p0), 32'd0);
      chk("ill_no_wen", 32'(wen_count - w0), 32'd0);

      // Mul/div disabled: mul is illegal, shift still goes to MDS
      decode_valid2 = 1'b1; op_type = 2'd1; op = 6'b001000; rd_addr = 6'd5;
      @(negedge clock);
      decode_valid2 = 1'b0;
      chk("nomd_exc", 32'(exec_exc2), 32'd1);
      chk("nomd_cause", 32'(exc_cause2), 32'd1);
      chk("nomd_no_issue", 32'(mds_in_valid2), 32'd0);
      @(negedge clock);
      chk("nomd_no_wen", 32'(rd_wen2), 32'd0);
      chk("nomd_ready", 32'(exec_ready2), 32'd1);
      decode_valid2 = 1'b1; op = 6'b000101;
      @(negedge clock);
      decode_valid2 = 1'b0;
      chk("nomd_shift_issue", 32'(mds_in_valid2), 32'd1);
      idle_cycles(5);
      chk("nomd_shift_to", {29'd0, exc_cause2, exec_exc2}, 32'd5);

      // Back-to-back with decode_valid held high
      issue(2'd0, 6'd0, 32'd10, 32'd1, 6'd20, 1, 32'd11, 2'd0, 2, 1'b1, n0);
      issue(2'd0, 6'd0, 32'd20, 32'd2, 6'd21, 1, 32'd22, 2'd0, 2, 1'b1, n1);
      issue(2'd0, 6'd0, 32'd30, 32'd3, 6'd22, 1, 32'd33, 2'd0, 2, 1'b1, n2);
      issue(2'd0, 6'd0, 32'd40, 32'd4, 6'd23, 1, 32'd44, 2'd0, 2, 1'b0, n3);
      chk("b2b_gap1", 32'(n1 - n0), 32'd3);
      chk("b2b_gap3", 32'(n3 - n2), 32'd3);
      idle_cycles(4);

      // Reset during MDS_WAIT; the late result must be ignored
      m_delay = 5; m_val = 32'h00001234;
      w0 = wen_count;
      issue(2'd1, 6'd1, 32'd1, 32'd1, 6'd7, 0, 32'd0, 2'd0, 0, 1'b0, n);
      idle_cycles(2);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("rst_mid_ready", 32'(exec_ready), 32'd1);
      idle_cycles(8);
      chk("rst_mid_no_wen", 32'(wen_count - w0), 32'd0);
      chk("rst_mid_wdata", rd_wdata, 32'd0);

      idle_cycles(5);
      chk("sb_empty", 32'(sbq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
